// File: rtl/openhw_bmu_pkg.sv
// Shared types for the bit-manipulation unit: count-op encodings and operand-stage occupancy.
package openhw_bmu_pkg;

    typedef enum logic [1:0] {
        CNT_CLZ  = 2'b00,
        CNT_CTZ  = 2'b01,
        CNT_CPOP = 2'b10
    } cnt_op_t;

    typedef enum logic [1:0] {
        OPS_EMPTY,
        OPS_ONE,
        OPS_TWO
    } opstage_state_t;

endpackage

// File: rtl/openhw_bitrev.sv
// Combinational bit reverse: y[i] = a[WIDTH-1-i].
// Latency: zero; no flow control.
module openhw_bitrev #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign y[i] = a[WIDTH-1-i];
    end

endmodule

// File: rtl/openhw_flopenr.sv
// Flop with enable, synchronous active-high reset and synchronous clear to zero.
// Latency: one cycle; no flow control of its own.
module openhw_flopenr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/openhw_cnt_opstage.sv
// Two-entry elastic operand stage feeding the count unit; outputs are flop-only, 1 cycle latency.
// Backpressure: InReady drops only when both entries are full and never depends on OutReady.
module openhw_cnt_opstage
    import openhw_bmu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushE,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [1:0]       OpIn,
    input  logic             W64In,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] RevA,
    output logic [1:0]       B,
    output logic             W64
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("openhw_cnt_opstage: WIDTH must be 32 or 64");
    end

    localparam int   EW   = 2*WIDTH + 3;
    localparam logic IS64 = (WIDTH == 64);

    opstage_state_t   state_q, state_d;
    logic             accept, pop, head_en, skid_en;
    logic [WIDTH-1:0] src_rev;
    logic [EW-1:0]    in_ent, head_d, head_q, skid_q;

    assign InReady  = (state_q != OPS_TWO);
    assign OutValid = (state_q != OPS_EMPTY);
    assign accept   = InValid && InReady;
    assign pop      = OutValid && OutReady;

    // Reversal happens before storage so the counter only ever sees flop outputs.
    openhw_bitrev #(.WIDTH(WIDTH)) u_bitrev (
        .a (SrcA),
        .y (src_rev)
    );

    assign in_ent = {W64In & IS64, OpIn, src_rev, SrcA};

    // Head loads new data when empty or replacing a popped entry; from skid when draining TWO.
    assign head_en = (accept && (state_q == OPS_EMPTY || pop)) || (pop && state_q == OPS_TWO);
    assign head_d  = (state_q == OPS_TWO) ? skid_q : in_ent;
    assign skid_en = accept && !pop && (state_q == OPS_ONE);

    openhw_flopenr #(.WIDTH(EW)) u_head (
        .clk   (clk),
        .reset (reset),
        .clear (FlushE),
        .en    (head_en),
        .d     (head_d),
        .q     (head_q)
    );

    openhw_flopenr #(.WIDTH(EW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .clear (FlushE),
        .en    (skid_en),
        .d     (in_ent),
        .q     (skid_q)
    );

    assign {W64, B, RevA, A} = head_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OPS_EMPTY: if (accept) state_d = OPS_ONE;
            OPS_ONE: begin
                if (accept && !pop)      state_d = OPS_TWO;
                else if (pop && !accept) state_d = OPS_EMPTY;
            end
            OPS_TWO:   if (pop) state_d = OPS_ONE;
            default:   state_d = OPS_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            state_q <= OPS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (reset || FlushE)
        (OutValid && !OutReady) |=> (OutValid && $stable(head_q)));

    a_no_accept_full: assert property (@(posedge clk) disable iff (reset)
        !(InValid && InReady && state_q == OPS_TWO));

endmodule

// File: tb/tb_openhw_cnt_opstage.sv
// Scoreboard bench: a 32-bit and a 64-bit instance share the same handshake stimulus.
module tb_openhw_cnt_opstage;

    typedef struct {
        logic [63:0] a;
        logic [1:0]  op;
        logic        w;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        FlushE = 1'b0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic [63:0] src = '0;
    logic [1:0]  OpIn = '0;
    logic        W64In = 1'b0;

    logic        ir32, ov32, w32, ir64, ov64, w64;
    logic [31:0] a32, reva32;
    logic [63:0] a64, reva64;
    logic [1:0]  b32, b64;

    exp_t        q[$];
    int          cnt = 0;
    bit          last_acc;
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    openhw_cnt_opstage #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .InValid(InValid), .InReady(ir32),
        .SrcA(src[31:0]), .OpIn(OpIn), .W64In(W64In), .OutValid(ov32), .OutReady(OutReady),
        .A(a32), .RevA(reva32), .B(b32), .W64(w32)
    );

    openhw_cnt_opstage #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .InValid(InValid), .InReady(ir64),
        .SrcA(src), .OpIn(OpIn), .W64In(W64In), .OutValid(ov64), .OutReady(OutReady),
        .A(a64), .RevA(reva64), .B(b64), .W64(w64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Checks the current cycle against the model, then advances one clock.
    task automatic step();
        bit   acc, pp;
        exp_t e;
        chk("inready32",  ir32, cnt != 2);
        chk("inready64",  ir64, cnt != 2);
        chk("outvalid32", ov32, cnt != 0);
        chk("outvalid64", ov64, cnt != 0);
        acc = InValid && (cnt < 2) && !reset && !FlushE;
        pp  = OutReady && (cnt > 0) && !reset && !FlushE;
        if (pp) begin
            e = q.pop_front();
            chk("a32",    a32,    e.a[31:0]);
            chk("reva32", reva32, rev32(e.a[31:0]));
            chk("b32",    b32,    e.op);
            chk("w32",    w32,    1'b0);
            chk("a64",    a64,    e.a);
            chk("reva64", reva64, rev64(e.a));
            chk("b64",    b64,    e.op);
            chk("w64",    w64,    e.w);
        end
        if (reset || FlushE) begin
            q.delete();
            cnt = 0;
        end else begin
            if (acc) begin
                e.a = src; e.op = OpIn; e.w = W64In;
                q.push_back(e);
            end
            cnt = cnt + int'(acc) - int'(pp);
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_op();
        src   = {$urandom, $urandom};
        OpIn  = 2'($urandom_range(0, 3));
        W64In = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [63:0] d [4];
        int idx;
        bit pending;

        // Reset with a request pending: nothing may be captured.
        InValid = 1'b1;
        src = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        InValid = 1'b0;
        chk("rst_outvalid", ov32, 1'b0);
        chk("rst_inready",  ir32, 1'b1);
        chk("rst_a",        a64,  64'h0);
        chk("rst_reva",     reva32, 32'h0);
        step();

        // Single op, reversed operand visible the next cycle.
        src = 64'h1; OpIn = 2'b01; W64In = 1'b0; InValid = 1'b1; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        chk("t2_a",    a32,    32'h1);
        chk("t2_reva", reva32, 32'h8000_0000);
        chk("t2_b",    b32,    2'b01);
        chk("t2_ov",   ov32,   1'b1);
        step();

        // Four requests against a stalled consumer: only two fit.
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            src = d[idx]; OpIn = 2'(idx); InValid = 1'b1;
            step();
            if (last_acc) idx++;
        end
        chk("t3_accepted", idx, 2);
        chk("t3_inready",  ir32, 1'b0);

        // Full with pop and request together: pop only, then ready again.
        OutReady = 1'b1;
        src = d[idx]; OpIn = 2'(idx);
        step();
        chk("t4_noacc",  last_acc, 1'b0);
        chk("t4_inready", ir64, 1'b1);
        for (int i = 0; i < 6 && idx < 4; i++) begin
            src = d[idx]; OpIn = 2'(idx); InValid = 1'b1;
            step();
            if (last_acc) idx++;
        end
        InValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t3_drained", q.size(), 0);

        // Word flag handling on both widths.
        src = 64'hFFFF_FFFF_0000_0000; W64In = 1'b1; OpIn = 2'b10; InValid = 1'b1; OutReady = 1'b0;
        step();
        InValid = 1'b0;
        chk("t5_w64",    w64,    1'b1);
        chk("t5_reva64", reva64, 64'h0000_0000_FFFF_FFFF);
        chk("t5_w32",    w32,    1'b0);
        OutReady = 1'b1;
        step();

        // Flush while full with a concurrent request.
        OutReady = 1'b0; InValid = 1'b1;
        new_op(); step();
        new_op(); step();
        new_op(); FlushE = 1'b1;
        step();
        FlushE = 1'b0; InValid = 1'b0;
        chk("t6_ov",     ov32,   1'b0);
        chk("t6_ir",     ir32,   1'b1);
        chk("t6_a",      a32,    32'h0);
        chk("t6_reva64", reva64, 64'h0);
        chk("t6_b",      b64,    2'b00);
        OutReady = 1'b1; InValid = 1'b1; new_op();
        step();
        InValid = 1'b0;
        step();
        chk("t6_q", q.size(), 0);

        // Random traffic with occasional flushes; held requests obey the protocol.
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                new_op();
                pending = 1'b1;
            end
            InValid  = pending;
            OutReady = 1'($urandom_range(0, 2) != 0);
            FlushE   = ($urandom_range(0, 39) == 0);
            step();
            if (last_acc) pending = 1'b0;
        end
        FlushE = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("final_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
